key_reset_ctrl: RTL and testbench
=================================

// Module: key_reset_ctrl
// PURPOSE
//  Front end of the board reset path: turns the raw push-button (KEY1) into clean
//  warm and cold reset requests for the MIPSfpga system (SI_Reset / SI_ColdReset).
//  It synchronises and debounces the key, then runs a small FSM.
//  - A short press gives a stretched warm reset.
//  - A long press also gives a cold reset.
//  - Power-on reset (the reset input) gives both.
//  It sits between the board pin and mfp_system, on the same slow clock as the power-on reset generator.
// PARAMETERS
//  KEY_ACTIVE_LOW   1      1: key pin reads 0 when pressed; 0: pin reads 1 when pressed
//  DEBOUNCE_CYCLES  1024   consecutive stable synced samples before key_level changes (>=1)
//  STRETCH_CYCLES   64     cycles resets stay asserted after POR end / debounced release (>=1)
//  LONG_PRESS_CYCLES 4096  cycles in PRESSED before the cold reset asserts (>=1)
// PORTS
//  clk            in   1  system clock
//  reset          in   1  synchronous, active-high reset
//  key_raw        in   1  asynchronous button pin
//  key_level      out  1  debounced key state, 1 = pressed
//  key_press      out  1  one-cycle pulse on debounced 0->1 of key_level
//  si_reset       out  1  warm reset request to mfp_system, active high
//  si_cold_reset  out  1  cold reset request to mfp_system, active high
// BEHAVIOUR
//  Reset values: key_level=0, key_press=0, si_reset=1, si_cold_reset=1, state=POR, all counters 0.
//  Synchroniser: 2 flops, reset to the released level. Polarity is normalised after the second flop.
//  Debounce:
//  - the counter increments while the synced value differs from key_level, and clears when it matches;
//  - on reaching DEBOUNCE_CYCLES, key_level flips and the counter clears.
//  - Pin latency: a clean edge that is stable from cycle 0 changes key_level at cycle 2+DEBOUNCE_CYCLES.
//  key_press: a registered pulse in the same cycle key_level goes 1. It never fires on release.
//  FSM outputs are registered and follow the state by 1 cycle.
//  FSM states:
//  - POR: si_reset=1, si_cold_reset=1. The stretch counter counts from the cycle reset is low.
//    After STRETCH_CYCLES -> IDLE. Both outputs are 0 in the following cycle.
//  - IDLE: both outputs 0. key_press -> PRESSED, hold counter cleared. si_reset=1 the next cycle.
//  - PRESSED: si_reset=1, hold counter increments.
//    Hold counter reaches LONG_PRESS_CYCLES -> COLD (si_cold_reset=1 next cycle).
//    key_level=0 -> STRETCH.
//  - COLD: si_reset=1, si_cold_reset=1, hold counter frozen. key_level=0 -> STRETCH.
//  - STRETCH: si_reset=1; si_cold_reset holds its value from entry.
//    The counter runs STRETCH_CYCLES, then -> IDLE, and both outputs drop together.
//    key_press during STRETCH -> PRESSED; the hold counter restarts and si_cold_reset keeps its current value.
//  Simultaneous events:
//  - reset wins over everything;
//  - in PRESSED, release and long-press in the same cycle -> STRETCH with si_cold_reset=1.
//  Reset mid-operation (any state): next cycle POR, both outputs 1, debounce and sync state cleared.
//  Widths:
//  - counters are $clog2(param+1) bits;
//  - counters saturate, never wrap;
//  - the hold counter stops at LONG_PRESS_CYCLES.
//  Outputs are glitch-free (all from flops). No combinational path from key_raw to any output.
// STRUCTURE
//  Shared header key_reset_defs.vh:
//  - FSM state localparams: POR=3'd0, IDLE=3'd1, PRESSED=3'd2, COLD=3'd3, STRETCH=3'd4;
//  - default parameter values.
//  One sub-module, key_debounce: synchroniser + debounce counter + key_press pulse.
//  It takes KEY_ACTIVE_LOW and DEBOUNCE_CYCLES.
//  The FSM, stretch counter and hold counter live in key_reset_ctrl.
// TESTING  (DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8, LONG_PRESS_CYCLES=20, KEY_ACTIVE_LOW=1)
//  1. Reset high 3 cycles, key_raw=1 -> both resets 1 during reset and 8 cycles after; both 0 at cycle 9; key_level 0 throughout.
//  2. key_raw toggles every 2 cycles for 30 cycles -> key_level, key_press, si_reset stay 0.
//  3. key_raw=0 for 12 cycles, then 1:
//     - key_level=1 at cycle 6 with a single key_press; si_reset=1 at cycle 7; si_cold_reset stays 0;
//     - si_reset drops 8 cycles after key_level returns to 0.
//  4. key_raw=0 for 40 cycles -> si_cold_reset=1 one cycle after the hold counter hits 20; both drop together 8 cycles after debounced release.
//  5. Reset pulse (1 cycle) while in COLD -> next cycle POR, both 1, key_level 0; normal POR stretch follows.
//  6. Re-press 3 cycles into STRETCH -> si_reset stays 1 without a gap; hold counter restarts from 0.

Source files
------------

// File: rtl/key_reset_ctrl_pkg.sv
// Shared definitions for the push-button reset path: FSM state encodings,
// parameter defaults and a counter-width helper.
package key_reset_ctrl_pkg;

  localparam logic [2:0] ST_POR     = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_PRESSED = 3'd2;
  localparam logic [2:0] ST_COLD    = 3'd3;
  localparam logic [2:0] ST_STRETCH = 3'd4;

  localparam int DEF_KEY_ACTIVE_LOW    = 1;
  localparam int DEF_DEBOUNCE_CYCLES   = 1024;
  localparam int DEF_STRETCH_CYCLES    = 64;
  localparam int DEF_LONG_PRESS_CYCLES = 4096;

  // Width of a counter that must be able to hold max_count itself.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser, debounce counter and press pulse for the board key.
// key_level is 1 while the key is pressed regardless of pin polarity.
module key_debounce
  import key_reset_ctrl_pkg::*;
#(
  parameter int KEY_ACTIVE_LOW  = DEF_KEY_ACTIVE_LOW,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_level,
  output logic key_press
);

  localparam int             DB_W         = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_TC       = DB_W'(DEBOUNCE_CYCLES);
  localparam logic           RAW_RELEASED = (KEY_ACTIVE_LOW != 0);

  logic            sync_1;
  logic            sync_2;
  logic            key_synced;
  logic [DB_W-1:0] db_cnt;

  assign key_synced = sync_2 ^ RAW_RELEASED;

  // The flip happens on the cycle after the counter holds DEBOUNCE_CYCLES,
  // so a clean edge lands on key_level 2+DEBOUNCE_CYCLES cycles after the pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1    <= RAW_RELEASED;
      sync_2    <= RAW_RELEASED;
      key_level <= 1'b0;
      key_press <= 1'b0;
      db_cnt    <= '0;
    end else begin
      sync_1    <= key_raw;
      sync_2    <= sync_1;
      key_press <= 1'b0;
      if (db_cnt == DB_TC) begin
        key_level <= ~key_level;
        key_press <= ~key_level;
        db_cnt    <= '0;
      end else if (key_synced != key_level) begin
        db_cnt <= db_cnt + 1'b1;
      end else begin
        db_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/key_reset_ctrl.sv
// Push-button to SI_Reset / SI_ColdReset request generator for mfp_system.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   POR     | power-on reset stretch, both requests asserted
//   IDLE    | no request, waiting for a debounced press
//   PRESSED | key held, warm reset asserted, hold counter running
//   COLD    | long press reached, warm and cold reset asserted
//   STRETCH | key released, requests held for STRETCH_CYCLES more cycles
module key_reset_ctrl
  import key_reset_ctrl_pkg::*;
#(
  parameter int KEY_ACTIVE_LOW    = DEF_KEY_ACTIVE_LOW,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int STRETCH_CYCLES    = DEF_STRETCH_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic si_reset,
  output logic si_cold_reset
);

  localparam int                   STRETCH_W  = cnt_width(STRETCH_CYCLES);
  localparam int                   HOLD_W     = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [STRETCH_W-1:0] STRETCH_TC = STRETCH_W'(STRETCH_CYCLES);
  localparam logic [HOLD_W-1:0]    HOLD_TC    = HOLD_W'(LONG_PRESS_CYCLES);

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [STRETCH_W-1:0] stretch_cnt;
  logic [STRETCH_W-1:0] stretch_nxt;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [HOLD_W-1:0]    hold_nxt;
  logic                 warm_nxt;
  logic                 cold_nxt;

  key_debounce #(
    .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .key_raw   (key_raw),
    .key_level (key_level),
    .key_press (key_press)
  );

  // Entering STRETCH counts the release-detect cycle as the first stretch
  // cycle, so release and POR end hold the requests equally long.
  always_comb begin
    state_nxt   = state;
    stretch_nxt = stretch_cnt;
    hold_nxt    = hold_cnt;
    cold_nxt    = si_cold_reset;
    case (state)
      ST_POR: begin
        if (stretch_cnt == STRETCH_TC) begin
          state_nxt   = ST_IDLE;
          stretch_nxt = '0;
          cold_nxt    = 1'b0;
        end else begin
          stretch_nxt = stretch_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        cold_nxt = 1'b0;
        if (key_press) begin
          state_nxt = ST_PRESSED;
          hold_nxt  = '0;
        end
      end
      ST_PRESSED: begin
        if (!key_level) begin
          state_nxt   = ST_STRETCH;
          stretch_nxt = STRETCH_W'(1);
          if (hold_cnt == HOLD_TC) cold_nxt = 1'b1;
        end else if (hold_cnt == HOLD_TC) begin
          state_nxt = ST_COLD;
          cold_nxt  = 1'b1;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      ST_COLD: begin
        cold_nxt = 1'b1;
        if (!key_level) begin
          state_nxt   = ST_STRETCH;
          stretch_nxt = STRETCH_W'(1);
        end
      end
      ST_STRETCH: begin
        // A re-press keeps whatever cold request is already active.
        if (key_press) begin
          state_nxt = ST_PRESSED;
          hold_nxt  = '0;
        end else if (stretch_cnt == STRETCH_TC) begin
          state_nxt   = ST_IDLE;
          stretch_nxt = '0;
          cold_nxt    = 1'b0;
        end else begin
          stretch_nxt = stretch_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt   = ST_POR;
        stretch_nxt = '0;
        hold_nxt    = '0;
        cold_nxt    = 1'b1;
      end
    endcase
  end

  assign warm_nxt = (state_nxt != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_POR;
      stretch_cnt   <= '0;
      hold_cnt      <= '0;
      si_reset      <= 1'b1;
      si_cold_reset <= 1'b1;
    end else begin
      state         <= state_nxt;
      stretch_cnt   <= stretch_nxt;
      hold_cnt      <= hold_nxt;
      si_reset      <= warm_nxt;
      si_cold_reset <= cold_nxt;
    end
  end

endmodule

// File: tb/tb_key_reset_ctrl.sv
// Bench for key_reset_ctrl: directed scenarios plus random key activity,
// checked every cycle against a timestamp-based behavioural model.
module tb_key_reset_ctrl;

  localparam int D = 4;
  localparam int S = 8;
  localparam int L = 20;

  localparam int PH_POR     = 0;
  localparam int PH_IDLE    = 1;
  localparam int PH_HELD    = 2;
  localparam int PH_RELEASE = 3;

  logic clk = 1'b0;
  logic reset;
  logic key_raw;
  logic key_level;
  logic key_press;
  logic si_reset;
  logic si_cold_reset;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit m_level, m_press, m_warm, m_cold;
  int phase, press_at, drop_at, last_flip;
  bit rq[$];
  bit synq[$];

  always #5 clk = ~clk;

  key_reset_ctrl #(
    .KEY_ACTIVE_LOW    (1),
    .DEBOUNCE_CYCLES   (D),
    .STRETCH_CYCLES    (S),
    .LONG_PRESS_CYCLES (L)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_raw       (key_raw),
    .key_level     (key_level),
    .key_press     (key_press),
    .si_reset      (si_reset),
    .si_cold_reset (si_cold_reset)
  );

  function automatic void model_reset();
    m_level   = 1'b0;
    m_press   = 1'b0;
    m_warm    = 1'b1;
    m_cold    = 1'b1;
    phase     = PH_POR;
    drop_at   = cyc + S + 1;
    last_flip = cyc;
    rq        = {1'b0, 1'b0};
    synq      = {};
  endfunction

  // Requests are modelled by timestamps: when the press was accepted and
  // the cycle at which the stretched requests fall.
  function automatic void model_step();
    bit pl, pp, synced, flip;
    cyc++;
    if (reset) begin
      model_reset();
      return;
    end
    pl = m_level;
    pp = m_press;
    case (phase)
      PH_POR: if (cyc >= drop_at) begin
        phase = PH_IDLE; m_warm = 0; m_cold = 0;
      end
      PH_IDLE: if (pp) begin
        phase = PH_HELD; press_at = cyc; m_warm = 1;
      end
      PH_HELD: begin
        if (!pl) begin
          if (cyc - press_at > L) m_cold = 1;
          phase   = PH_RELEASE;
          drop_at = cyc + S;
        end else if (cyc - press_at > L) begin
          m_cold = 1;
        end
      end
      default: begin
        if (pp) begin
          phase = PH_HELD; press_at = cyc;
        end else if (cyc >= drop_at) begin
          phase = PH_IDLE; m_warm = 0; m_cold = 0;
        end
      end
    endcase
    synced = rq.pop_front();
    rq.push_back(!key_raw);
    flip = 0;
    if ((cyc - last_flip >= D + 1) && (synq.size() == D)) begin
      flip = 1;
      foreach (synq[i]) if (synq[i] == m_level) flip = 0;
    end
    m_press = flip && !m_level;
    if (flip) begin
      m_level   = !m_level;
      last_flip = cyc;
    end
    synq.push_back(synced);
    if (synq.size() > D) void'(synq.pop_front());
  endfunction

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("key_level", key_level, m_level);
    chk("key_press", key_press, m_press);
    chk("si_reset", si_reset, m_warm);
    chk("si_cold_reset", si_cold_reset, m_cold);
  endtask

  initial begin
    reset   = 1'b1;
    key_raw = 1'b1;

    // 1: power-on reset and stretch
    repeat (3) begin
      tick();
      chk("rst_warm", si_reset, 1'b1);
      chk("rst_cold", si_cold_reset, 1'b1);
    end
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 8) chk("por_last_warm", si_reset, 1'b1);
      if (i == 8) chk("por_last_cold", si_cold_reset, 1'b1);
      if (i == 9) chk("por_end_warm", si_reset, 1'b0);
      if (i == 9) chk("por_end_cold", si_cold_reset, 1'b0);
    end

    // 2: bounce shorter than the debounce window
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) key_raw = ~key_raw;
      tick();
      chk("bounce_level", key_level, 1'b0);
      chk("bounce_warm", si_reset, 1'b0);
    end
    key_raw = 1'b1;
    repeat (10) tick();

    // 3: short press
    key_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 5) chk("short_level_early", key_level, 1'b0);
      if (i == 6) chk("short_level", key_level, 1'b1);
      if (i == 6) chk("short_press", key_press, 1'b1);
      if (i == 7) chk("short_warm", si_reset, 1'b1);
      chk("short_cold", si_cold_reset, 1'b0);
    end
    key_raw = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (j == 6)  chk("short_rel_level", key_level, 1'b0);
      if (j == 14) chk("short_stretch_warm", si_reset, 1'b1);
      if (j == 15) chk("short_drop_warm", si_reset, 1'b0);
    end

    // 4: long press
    key_raw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 27) chk("long_cold_early", si_cold_reset, 1'b0);
      if (i == 28) chk("long_cold", si_cold_reset, 1'b1);
    end
    key_raw = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (j == 14) chk("long_stretch_cold", si_cold_reset, 1'b1);
      if (j == 15) chk("long_drop_warm", si_reset, 1'b0);
      if (j == 15) chk("long_drop_cold", si_cold_reset, 1'b0);
    end

    // 5: reset pulse while in COLD
    key_raw = 1'b0;
    repeat (35) tick();
    chk("cold_before_rst", si_cold_reset, 1'b1);
    reset = 1'b1;
    tick();
    chk("midrst_warm", si_reset, 1'b1);
    chk("midrst_cold", si_cold_reset, 1'b1);
    chk("midrst_level", key_level, 1'b0);
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 9) chk("midrst_por_end", si_reset, 1'b0);
    end
    key_raw = 1'b1;
    repeat (15) tick();

    // 6: re-press during STRETCH
    for (int i = 0; i < 64; i++) begin
      key_raw = (i < 12 || (i >= 16 && i < 50)) ? 1'b0 : 1'b1;
      tick();
      if (i >= 7 && i <= 50) chk("repress_no_gap", si_reset, 1'b1);
      if (i == 44) chk("repress_hold_restart", si_cold_reset, 1'b0);
      if (i == 45) chk("repress_cold", si_cold_reset, 1'b1);
    end

    // random key activity with occasional glitches and resets
    for (int seg = 0; seg < 40; seg++) begin
      logic base;
      int   len;
      base = seg[0];
      len  = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        key_raw = base ^ ($urandom_range(0, 15) == 0);
        reset   = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    reset   = 1'b0;
    key_raw = 1'b1;
    repeat (60) tick();
    chk("final_warm", si_reset, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
